wb_load_commit: RTL and testbench
=================================

// Module: wb_load_commit
// PURPOSE
//  Parametrised write-back stage: registers MEM-stage results, aligns/extends load data (byte/half/word/dword),
//  waits on a variable-latency RAM read response, raises address/bus errors, issues one write-back commit per instr.
//  Sits between MEM and regfile/CP0; wb_stall back-pressures the pipeline while a load is outstanding.
// PARAMETERS
//  DATA_WIDTH      32  datapath width; 32 or 64 (dword loads legal only when 64)
//  ADDR_WIDTH      32  address / PC width
//  REG_ADDR_WIDTH  5   regfile and CP0 register address width
//  TIMEOUT         15  max cycles waiting for ram_read_valid before bus_error (1..255)
// PORTS
//  clk                 in   1               clock, rising edge
//  rst                 in   1               synchronous reset, active-high
//  in_valid            in   1               MEM-stage instruction valid this cycle (sampled only when wb_stall=0)
//  flush               in   1               exception flush; abort outstanding load, drop in-flight commit
//  mem_read_flag       in   1               instruction is a load
//  mem_write_flag      in   1               instruction is a store
//  mem_sign_ext_flag   in   1               1 = sign-extend loaded value, 0 = zero-extend
//  mem_size            in   2               00 byte, 01 half, 10 word, 11 dword
//  result_in           in   DATA_WIDTH      ALU result; for loads/stores the effective address
//  reg_write_en_in     in   1               regfile write request
//  reg_write_addr_in   in   REG_ADDR_WIDTH  regfile destination
//  cp_write_en_in      in   1               CP0 write request
//  cp_write_addr_in    in   REG_ADDR_WIDTH  CP0 destination
//  current_pc_addr_in  in   ADDR_WIDTH      PC of the instruction
//  ram_read_valid      in   1               ram_read_data valid this cycle
//  ram_read_data       in   DATA_WIDTH      aligned RAM word (lane 0 = address offset 0)
//  result_out          out  DATA_WIDTH      write-back data
//  reg_write_en_out    out  1               regfile write strobe (1-cycle pulse)
//  reg_write_addr_out  out  REG_ADDR_WIDTH  regfile address
//  cp_write_en_out     out  1               CP0 write strobe (1-cycle pulse)
//  cp_write_addr_out   out  REG_ADDR_WIDTH  CP0 address
//  wb_stall            out  1               load outstanding; upstream must hold
//  load_addr_error     out  1               misaligned load pulse (AdEL)
//  bus_error           out  1               RAM timeout pulse
//  bad_vaddr           out  ADDR_WIDTH      faulting address, valid with either error pulse
//  debug_reg_write_en  out  1               = reg_write_en_out
//  debug_pc_addr_out   out  ADDR_WIDTH      PC of committing/faulting instruction
// BEHAVIOUR
//  Reset: state IDLE, every output 0, timeout counter 0. Outputs are registered.
//  States: IDLE, WAIT. Accept = in_valid & ~flush in IDLE.
//  IDLE, accept non-load: next cycle result_out = store ? 0 : result_in, write strobes = *_en_in; latency 1.
//  IDLE, accept load: alignment check on result_in low bits (half: [0], word: [1:0], dword: [2:0]).
//   Misaligned -> next cycle load_addr_error=1, bad_vaddr=address, no write strobes, stay IDLE.
//   Aligned -> latch ctrl/address, go WAIT, counter 0; wb_stall=1 from next cycle.
//  WAIT: ram_read_valid -> select lane by address offset, extend per mem_sign_ext_flag to DATA_WIDTH,
//   register result, pulse write strobes next cycle, return IDLE, wb_stall drops same edge.
//   ram_read_valid in the same cycle the load is accepted is ignored (data earliest 1 cycle later).
//  Timeout: counter increments each WAIT cycle without valid; reaching TIMEOUT -> bus_error pulse,
//   bad_vaddr=address, no write, return IDLE. Late ram_read_valid in IDLE is ignored.
//  flush: highest priority; from any state -> IDLE, all strobes/error pulses of that cycle suppressed.
//  rst mid-WAIT: IDLE, outputs cleared, pending load discarded.
//  dword (mem_size=11) with DATA_WIDTH=32: treated as misaligned -> load_addr_error.
//  Pulses (strobes, errors) last exactly one cycle; result_out/addresses hold until next commit.
// TESTING
//  Add, result_in=0x1234, reg_write_en_in=1, addr 5 -> next cycle result_out=0x1234, reg_write_en_out=1 for 1 cycle.
//  LB signed addr 0x...3, RAM 0x80FF_0000 after 3 cycles -> wb_stall 3 cycles, result_out=0xFFFF_FF80.
//  LHU addr 0x...2, RAM 0x8001_0000 -> result_out=0x0000_8001; LW addr 0x...2 -> load_addr_error, bad_vaddr=addr, no write.
//  LW, no ram_read_valid for TIMEOUT=15 cycles -> bus_error pulse on cycle 15, wb_stall drops, later valid ignored.
//  LW in WAIT, flush asserted concurrently with ram_read_valid -> no write strobe, IDLE next cycle.
//  DATA_WIDTH=64: LD addr 0x8, RAM 0x0123_4567_89AB_CDEF -> result_out equal; LWU addr 0xC -> 0x0000_0000_0123_4567.

Source files
------------

// File: rtl/wb_load_commit_if.sv
// Signal bundle between the MEM stage / data RAM (master side) and the write-back stage (slave side).
// The master drives the instruction fields and the RAM read response; the slave drives the commit outputs.
interface wb_load_commit_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      in_valid;
   logic                      flush;
   logic                      mem_read_flag;
   logic                      mem_write_flag;
   logic                      mem_sign_ext_flag;
   logic [1:0]                mem_size;
   logic [DATA_WIDTH-1:0]     result_in;
   logic                      reg_write_en_in;
   logic [REG_ADDR_WIDTH-1:0] reg_write_addr_in;
   logic                      cp_write_en_in;
   logic [REG_ADDR_WIDTH-1:0] cp_write_addr_in;
   logic [ADDR_WIDTH-1:0]     current_pc_addr_in;
   logic                      ram_read_valid;
   logic [DATA_WIDTH-1:0]     ram_read_data;

   logic [DATA_WIDTH-1:0]     result_out;
   logic                      reg_write_en_out;
   logic [REG_ADDR_WIDTH-1:0] reg_write_addr_out;
   logic                      cp_write_en_out;
   logic [REG_ADDR_WIDTH-1:0] cp_write_addr_out;
   logic                      wb_stall;
   logic                      load_addr_error;
   logic                      bus_error;
   logic [ADDR_WIDTH-1:0]     bad_vaddr;
   logic                      debug_reg_write_en;
   logic [ADDR_WIDTH-1:0]     debug_pc_addr_out;

   modport master (
      output in_valid, flush, mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_size,
             result_in, reg_write_en_in, reg_write_addr_in, cp_write_en_in, cp_write_addr_in,
             current_pc_addr_in, ram_read_valid, ram_read_data,
      input  result_out, reg_write_en_out, reg_write_addr_out, cp_write_en_out, cp_write_addr_out,
             wb_stall, load_addr_error, bus_error, bad_vaddr, debug_reg_write_en, debug_pc_addr_out
   );

   modport slave (
      input  in_valid, flush, mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_size,
             result_in, reg_write_en_in, reg_write_addr_in, cp_write_en_in, cp_write_addr_in,
             current_pc_addr_in, ram_read_valid, ram_read_data,
      output result_out, reg_write_en_out, reg_write_addr_out, cp_write_en_out, cp_write_addr_out,
             wb_stall, load_addr_error, bus_error, bad_vaddr, debug_reg_write_en, debug_pc_addr_out
   );
endinterface

// File: rtl/wb_load_commit.sv
// Write-back stage: registers MEM results, waits for variable-latency load data, aligns/extends it,
// flags misaligned loads and RAM timeouts, and emits one registered commit per instruction.
module wb_load_commit #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int TIMEOUT        = 15
) (
   input logic             clk,
   input logic             rst,
   wb_load_commit_if.slave bus
);
   localparam int OFF_W = $clog2(DATA_WIDTH / 8);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                    state, state_nxt;
   logic [7:0]                wait_cnt, wait_cnt_nxt;

   logic [ADDR_WIDTH-1:0]     ld_addr, ld_addr_nxt;
   logic [OFF_W-1:0]          ld_off, ld_off_nxt;
   logic [1:0]                ld_size, ld_size_nxt;
   logic                      ld_sign, ld_sign_nxt;
   logic                      ld_reg_en, ld_reg_en_nxt;
   logic [REG_ADDR_WIDTH-1:0] ld_reg_addr, ld_reg_addr_nxt;
   logic                      ld_cp_en, ld_cp_en_nxt;
   logic [REG_ADDR_WIDTH-1:0] ld_cp_addr, ld_cp_addr_nxt;
   logic [ADDR_WIDTH-1:0]     ld_pc, ld_pc_nxt;

   logic [DATA_WIDTH-1:0]     result_q, result_nxt;
   logic                      reg_en_q, reg_en_nxt;
   logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_nxt;
   logic                      cp_en_q, cp_en_nxt;
   logic [REG_ADDR_WIDTH-1:0] cp_addr_q, cp_addr_nxt;
   logic                      lae_q, lae_nxt;
   logic                      be_q, be_nxt;
   logic [ADDR_WIDTH-1:0]     bad_q, bad_nxt;
   logic [ADDR_WIDTH-1:0]     pc_q, pc_nxt;

   logic [ADDR_WIDTH-1:0]     in_addr;
   logic                      misaligned;
   logic                      timeout_hit;
   logic [DATA_WIDTH-1:0]     lane_data;
   logic [DATA_WIDTH-1:0]     lane_left;
   logic signed [DATA_WIDTH-1:0] lane_left_s;
   logic signed [DATA_WIDTH-1:0] lane_sext;
   logic [DATA_WIDTH-1:0]     load_value;
   logic [6:0]                ext_shift;

   assign in_addr     = ADDR_WIDTH'(bus.result_in);
   assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

   // Dword accesses only exist on a 64-bit datapath; on 32 bits they fault like a misaligned access.
   always_comb begin
      misaligned = 1'b0;
      case (bus.mem_size)
         2'b01:   misaligned = bus.result_in[0];
         2'b10:   misaligned = |bus.result_in[1:0];
         2'b11:   misaligned = (DATA_WIDTH != 64) || (|bus.result_in[2:0]);
         default: misaligned = 1'b0;
      endcase
   end

   // Move the addressed lane to the top, then shift back down arithmetically or logically to extend.
   always_comb begin
      ext_shift = 7'd0;
      case (ld_size)
         2'b00:   ext_shift = 7'(DATA_WIDTH - 8);
         2'b01:   ext_shift = 7'(DATA_WIDTH - 16);
         2'b10:   ext_shift = 7'(DATA_WIDTH - 32);
         default: ext_shift = 7'd0;
      endcase
      lane_data   = bus.ram_read_data >> {ld_off, 3'b000};
      lane_left   = lane_data << ext_shift;
      lane_left_s = lane_left;
      lane_sext   = lane_left_s >>> ext_shift;
      load_value  = ld_sign ? DATA_WIDTH'(lane_sext) : (lane_left >> ext_shift);
   end

   always_comb begin
      state_nxt       = state;
      wait_cnt_nxt    = wait_cnt;
      ld_addr_nxt     = ld_addr;
      ld_off_nxt      = ld_off;
      ld_size_nxt     = ld_size;
      ld_sign_nxt     = ld_sign;
      ld_reg_en_nxt   = ld_reg_en;
      ld_reg_addr_nxt = ld_reg_addr;
      ld_cp_en_nxt    = ld_cp_en;
      ld_cp_addr_nxt  = ld_cp_addr;
      ld_pc_nxt       = ld_pc;
      result_nxt      = result_q;
      reg_en_nxt      = 1'b0;
      reg_addr_nxt    = reg_addr_q;
      cp_en_nxt       = 1'b0;
      cp_addr_nxt     = cp_addr_q;
      lae_nxt         = 1'b0;
      be_nxt          = 1'b0;
      bad_nxt         = bad_q;
      pc_nxt          = pc_q;

      if (bus.flush) begin
         state_nxt    = S_IDLE;
         wait_cnt_nxt = 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  if (bus.mem_read_flag) begin
                     if (misaligned) begin
                        lae_nxt = 1'b1;
                        bad_nxt = in_addr;
                        pc_nxt  = bus.current_pc_addr_in;
                     end else begin
                        state_nxt       = S_WAIT;
                        wait_cnt_nxt    = 8'd0;
                        ld_addr_nxt     = in_addr;
                        ld_off_nxt      = bus.result_in[OFF_W-1:0];
                        ld_size_nxt     = bus.mem_size;
                        ld_sign_nxt     = bus.mem_sign_ext_flag;
                        ld_reg_en_nxt   = bus.reg_write_en_in;
                        ld_reg_addr_nxt = bus.reg_write_addr_in;
                        ld_cp_en_nxt    = bus.cp_write_en_in;
                        ld_cp_addr_nxt  = bus.cp_write_addr_in;
                        ld_pc_nxt       = bus.current_pc_addr_in;
                     end
                  end else begin
                     result_nxt   = bus.mem_write_flag ? '0 : bus.result_in;
                     reg_en_nxt   = bus.reg_write_en_in;
                     reg_addr_nxt = bus.reg_write_addr_in;
                     cp_en_nxt    = bus.cp_write_en_in;
                     cp_addr_nxt  = bus.cp_write_addr_in;
                     pc_nxt       = bus.current_pc_addr_in;
                  end
               end
            end
            S_WAIT: begin
               // Data arriving in the last allowed cycle still wins over the timeout.
               if (bus.ram_read_valid) begin
                  state_nxt    = S_IDLE;
                  wait_cnt_nxt = 8'd0;
                  result_nxt   = load_value;
                  reg_en_nxt   = ld_reg_en;
                  reg_addr_nxt = ld_reg_addr;
                  cp_en_nxt    = ld_cp_en;
                  cp_addr_nxt  = ld_cp_addr;
                  pc_nxt       = ld_pc;
               end else if (timeout_hit) begin
                  state_nxt    = S_IDLE;
                  wait_cnt_nxt = 8'd0;
                  be_nxt       = 1'b1;
                  bad_nxt      = ld_addr;
                  pc_nxt       = ld_pc;
               end else begin
                  wait_cnt_nxt = wait_cnt + 8'd1;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wait_cnt    <= 8'd0;
         ld_addr     <= '0;
         ld_off      <= '0;
         ld_size     <= 2'b00;
         ld_sign     <= 1'b0;
         ld_reg_en   <= 1'b0;
         ld_reg_addr <= '0;
         ld_cp_en    <= 1'b0;
         ld_cp_addr  <= '0;
         ld_pc       <= '0;
         result_q    <= '0;
         reg_en_q    <= 1'b0;
         reg_addr_q  <= '0;
         cp_en_q     <= 1'b0;
         cp_addr_q   <= '0;
         lae_q       <= 1'b0;
         be_q        <= 1'b0;
         bad_q       <= '0;
         pc_q        <= '0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         ld_addr     <= ld_addr_nxt;
         ld_off      <= ld_off_nxt;
         ld_size     <= ld_size_nxt;
         ld_sign     <= ld_sign_nxt;
         ld_reg_en   <= ld_reg_en_nxt;
         ld_reg_addr <= ld_reg_addr_nxt;
         ld_cp_en    <= ld_cp_en_nxt;
         ld_cp_addr  <= ld_cp_addr_nxt;
         ld_pc       <= ld_pc_nxt;
         result_q    <= result_nxt;
         reg_en_q    <= reg_en_nxt;
         reg_addr_q  <= reg_addr_nxt;
         cp_en_q     <= cp_en_nxt;
         cp_addr_q   <= cp_addr_nxt;
         lae_q       <= lae_nxt;
         be_q        <= be_nxt;
         bad_q       <= bad_nxt;
         pc_q        <= pc_nxt;
      end
   end

   assign bus.result_out         = result_q;
   assign bus.reg_write_en_out   = reg_en_q;
   assign bus.reg_write_addr_out = reg_addr_q;
   assign bus.cp_write_en_out    = cp_en_q;
   assign bus.cp_write_addr_out  = cp_addr_q;
   assign bus.wb_stall           = (state == S_WAIT);
   assign bus.load_addr_error    = lae_q;
   assign bus.bus_error          = be_q;
   assign bus.bad_vaddr          = bad_q;
   assign bus.debug_reg_write_en = reg_en_q;
   assign bus.debug_pc_addr_out  = pc_q;
endmodule

// File: tb/tb_wb_load_commit.sv
// Drives a 32-bit and a 64-bit write-back stage with the same stimulus and checks both every cycle
// against a transaction-level model (pending load + wait count), plus hand-computed literal checks.
module tb_wb_load_commit;
   localparam int TIMEOUT = 15;

   typedef struct {
      bit          rst;
      bit          in_valid;
      bit          flush;
      bit          rd;
      bit          wr;
      bit          sx;
      logic [1:0]  size;
      logic [63:0] res;
      bit          reg_en;
      logic [4:0]  reg_addr;
      bit          cp_en;
      logic [4:0]  cp_addr;
      logic [31:0] pc;
      bit          ram_valid;
      logic [63:0] ram;
   } stim_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_load_commit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) bus32 ();
   wb_load_commit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) bus64 ();

   wb_load_commit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT(TIMEOUT))
      dut32 (.clk(clk), .rst(rst), .bus(bus32));
   wb_load_commit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT(TIMEOUT))
      dut64 (.clk(clk), .rst(rst), .bus(bus64));

   int vectors = 0;
   int miscompares = 0;
   bit checking = 1'b0;

   // Model: per instance, whether a load is pending, how long it has waited, and its captured fields.
   bit          m_busy[2];
   int          m_waited[2];
   logic [31:0] m_addr[2];
   logic [1:0]  m_size[2];
   bit          m_sx[2];
   bit          m_reg_en[2];
   logic [4:0]  m_reg_addr[2];
   bit          m_cp_en[2];
   logic [4:0]  m_cp_addr[2];
   logic [31:0] m_pc[2];

   logic [63:0] e_result[2];
   bit          e_reg_en[2];
   logic [4:0]  e_reg_addr[2];
   bit          e_cp_en[2];
   logic [4:0]  e_cp_addr[2];
   bit          e_stall[2];
   bit          e_lae[2];
   bit          e_be[2];
   logic [31:0] e_bad[2];
   logic [31:0] e_pc[2];

   function automatic logic [63:0] loadValue(int dw, logic [63:0] data, logic [31:0] addr,
                                             logic [1:0] size, bit sx);
      int          nbits;
      int          off;
      logic [63:0] v;
      logic [63:0] mask;
      nbits = 8 << size;
      off   = int'(addr % (dw / 8));
      v     = data >> (8 * off);
      mask  = (nbits == 64) ? '1 : ((64'd1 << nbits) - 64'd1);
      v     = v & mask;
      if (sx && v[nbits-1]) v = v | ~mask;
      if (dw == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   task automatic modelStep(int i, stim_t s);
      int          dw;
      int          nbytes;
      logic [63:0] dmask;
      logic [31:0] addr;
      dw     = (i == 0) ? 32 : 64;
      dmask  = (i == 0) ? 64'hFFFF_FFFF : '1;
      addr   = s.res[31:0];
      nbytes = 1 << s.size;
      e_reg_en[i] = 1'b0;
      e_cp_en[i]  = 1'b0;
      e_lae[i]    = 1'b0;
      e_be[i]     = 1'b0;
      if (s.rst) begin
         m_busy[i]     = 1'b0;
         m_waited[i]   = 0;
         e_result[i]   = '0;
         e_reg_addr[i] = '0;
         e_cp_addr[i]  = '0;
         e_bad[i]      = '0;
         e_pc[i]       = '0;
      end else if (s.flush) begin
         m_busy[i] = 1'b0;
      end else if (!m_busy[i]) begin
         if (s.in_valid && s.rd) begin
            if ((s.size == 2'b11 && dw == 32) || (addr % nbytes) != 0) begin
               e_lae[i] = 1'b1;
               e_bad[i] = addr;
               e_pc[i]  = s.pc;
            end else begin
               m_busy[i]     = 1'b1;
               m_waited[i]   = 0;
               m_addr[i]     = addr;
               m_size[i]     = s.size;
               m_sx[i]       = s.sx;
               m_reg_en[i]   = s.reg_en;
               m_reg_addr[i] = s.reg_addr;
               m_cp_en[i]    = s.cp_en;
               m_cp_addr[i]  = s.cp_addr;
               m_pc[i]       = s.pc;
            end
         end else if (s.in_valid) begin
            e_result[i]   = s.wr ? 64'd0 : (s.res & dmask);
            e_reg_en[i]   = s.reg_en;
            e_reg_addr[i] = s.reg_addr;
            e_cp_en[i]    = s.cp_en;
            e_cp_addr[i]  = s.cp_addr;
            e_pc[i]       = s.pc;
         end
      end else if (s.ram_valid) begin
         e_result[i]   = loadValue(dw, s.ram & dmask, m_addr[i], m_size[i], m_sx[i]);
         e_reg_en[i]   = m_reg_en[i];
         e_reg_addr[i] = m_reg_addr[i];
         e_cp_en[i]    = m_cp_en[i];
         e_cp_addr[i]  = m_cp_addr[i];
         e_pc[i]       = m_pc[i];
         m_busy[i]     = 1'b0;
      end else begin
         m_waited[i]++;
         if (m_waited[i] == TIMEOUT) begin
            e_be[i]   = 1'b1;
            e_bad[i]  = m_addr[i];
            e_pc[i]   = m_pc[i];
            m_busy[i] = 1'b0;
         end
      end
      e_stall[i] = m_busy[i];
   endtask

   task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkLit(string name, logic [63:0] dutVal, logic [63:0] modelVal, logic [63:0] lit);
      cmp({name, "/dut"}, dutVal, lit);
      cmp({name, "/model"}, modelVal, lit);
   endtask

   task automatic checkInst(string tag, int i, logic [63:0] res, logic wen, logic [4:0] wa,
                            logic cen, logic [4:0] ca, logic stall, logic lae, logic be,
                            logic [31:0] bad, logic dwen, logic [31:0] pc);
      cmp({tag, ".result_out"}, res, e_result[i]);
      cmp({tag, ".reg_write_en_out"}, 64'(wen), 64'(e_reg_en[i]));
      cmp({tag, ".reg_write_addr_out"}, 64'(wa), 64'(e_reg_addr[i]));
      cmp({tag, ".cp_write_en_out"}, 64'(cen), 64'(e_cp_en[i]));
      cmp({tag, ".cp_write_addr_out"}, 64'(ca), 64'(e_cp_addr[i]));
      cmp({tag, ".wb_stall"}, 64'(stall), 64'(e_stall[i]));
      cmp({tag, ".load_addr_error"}, 64'(lae), 64'(e_lae[i]));
      cmp({tag, ".bus_error"}, 64'(be), 64'(e_be[i]));
      cmp({tag, ".bad_vaddr"}, 64'(bad), 64'(e_bad[i]));
      cmp({tag, ".debug_reg_write_en"}, 64'(dwen), 64'(e_reg_en[i]));
      cmp({tag, ".debug_pc_addr_out"}, 64'(pc), 64'(e_pc[i]));
   endtask

   task automatic checkOutput();
      checkInst("dw32", 0, 64'(bus32.result_out), bus32.reg_write_en_out, bus32.reg_write_addr_out,
                bus32.cp_write_en_out, bus32.cp_write_addr_out, bus32.wb_stall, bus32.load_addr_error,
                bus32.bus_error, bus32.bad_vaddr, bus32.debug_reg_write_en, bus32.debug_pc_addr_out);
      checkInst("dw64", 1, bus64.result_out, bus64.reg_write_en_out, bus64.reg_write_addr_out,
                bus64.cp_write_en_out, bus64.cp_write_addr_out, bus64.wb_stall, bus64.load_addr_error,
                bus64.bus_error, bus64.bad_vaddr, bus64.debug_reg_write_en, bus64.debug_pc_addr_out);
   endtask

   always @(negedge clk) begin
      if (checking) checkOutput();
   end

   // Drive one cycle of inputs, advance the model, and return just after the outputs settle.
   task automatic applyStimulus(stim_t s);
      rst                      = s.rst;
      bus32.in_valid           = s.in_valid;
      bus64.in_valid           = s.in_valid;
      bus32.flush              = s.flush;
      bus64.flush              = s.flush;
      bus32.mem_read_flag      = s.rd;
      bus64.mem_read_flag      = s.rd;
      bus32.mem_write_flag     = s.wr;
      bus64.mem_write_flag     = s.wr;
      bus32.mem_sign_ext_flag  = s.sx;
      bus64.mem_sign_ext_flag  = s.sx;
      bus32.mem_size           = s.size;
      bus64.mem_size           = s.size;
      bus32.result_in          = s.res[31:0];
      bus64.result_in          = s.res;
      bus32.reg_write_en_in    = s.reg_en;
      bus64.reg_write_en_in    = s.reg_en;
      bus32.reg_write_addr_in  = s.reg_addr;
      bus64.reg_write_addr_in  = s.reg_addr;
      bus32.cp_write_en_in     = s.cp_en;
      bus64.cp_write_en_in     = s.cp_en;
      bus32.cp_write_addr_in   = s.cp_addr;
      bus64.cp_write_addr_in   = s.cp_addr;
      bus32.current_pc_addr_in = s.pc;
      bus64.current_pc_addr_in = s.pc;
      bus32.ram_read_valid     = s.ram_valid;
      bus64.ram_read_valid     = s.ram_valid;
      bus32.ram_read_data      = s.ram[31:0];
      bus64.ram_read_data      = s.ram;
      modelStep(0, s);
      modelStep(1, s);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   function automatic stim_t idleStim(bit rv, logic [63:0] ram);
      stim_t s;
      s.rst = 1'b0; s.in_valid = 1'b0; s.flush = 1'b0; s.rd = 1'b0; s.wr = 1'b0; s.sx = 1'b0;
      s.size = 2'b00; s.res = '0; s.reg_en = 1'b0; s.reg_addr = '0; s.cp_en = 1'b0;
      s.cp_addr = '0; s.pc = '0; s.ram_valid = rv; s.ram = ram;
      return s;
   endfunction

   function automatic stim_t instr(bit rd, bit wr, bit sx, logic [1:0] size, logic [63:0] res,
                                   bit reg_en, logic [4:0] ra);
      stim_t s;
      s          = idleStim(1'b0, '0);
      s.in_valid = 1'b1;
      s.rd       = rd;
      s.wr       = wr;
      s.sx       = sx;
      s.size     = size;
      s.res      = res;
      s.reg_en   = reg_en;
      s.reg_addr = ra;
      s.pc       = 32'h0040_0000 | res[15:0];
      return s;
   endfunction

   function automatic stim_t randStim(int mode);
      stim_t       s;
      int          kind;
      logic [63:0] lowMask;
      s          = idleStim(1'b0, '0);
      s.rst      = ($urandom_range(0, 399) == 0);
      s.flush    = ($urandom_range(0, 29) == 0);
      s.in_valid = ($urandom_range(0, 9) < 7);
      kind       = int'($urandom_range(0, 19));
      s.rd       = (kind < 9);
      s.wr       = (kind >= 9) && (kind < 12);
      s.sx       = 1'($urandom_range(0, 1));
      s.size     = 2'($urandom_range(0, 3));
      s.res      = {$urandom, $urandom};
      lowMask    = (64'd1 << s.size) - 64'd1;
      if (s.rd && $urandom_range(0, 9) < 7) s.res = s.res & ~lowMask;
      s.reg_en   = 1'($urandom_range(0, 1));
      s.reg_addr = 5'($urandom);
      s.cp_en    = ($urandom_range(0, 4) == 0);
      s.cp_addr  = 5'($urandom);
      s.pc       = $urandom;
      s.ram      = {$urandom, $urandom};
      case (mode)
         0:       s.ram_valid = ($urandom_range(0, 1) == 1);
         1:       s.ram_valid = ($urandom_range(0, 9) == 0);
         default: s.ram_valid = 1'b0;
      endcase
      return s;
   endfunction

   initial begin
      stim_t s;
      rst = 1'b1;
      @(negedge clk);
      #1;
      checking = 1'b1;
      s = idleStim(1'b0, '0);
      s.rst = 1'b1;
      applyStimulus(s);
      applyStimulus(s);
      checkLit("reset_result", 64'(bus32.result_out), e_result[0], 64'd0);
      checkLit("reset_stall", 64'(bus32.wb_stall), 64'(e_stall[0]), 64'd0);

      applyStimulus(instr(1'b0, 1'b0, 1'b0, 2'b10, 64'h1234, 1'b1, 5'd5));
      checkLit("alu_result", 64'(bus32.result_out), e_result[0], 64'h1234);
      checkLit("alu_wen", 64'(bus32.reg_write_en_out), 64'(e_reg_en[0]), 64'd1);
      checkLit("alu_waddr", 64'(bus32.reg_write_addr_out), 64'(e_reg_addr[0]), 64'd5);
      applyStimulus(idleStim(1'b0, '0));
      checkLit("alu_pulse_end", 64'(bus32.reg_write_en_out), 64'(e_reg_en[0]), 64'd0);

      applyStimulus(instr(1'b1, 1'b0, 1'b1, 2'b00, 64'h1003, 1'b1, 5'd7));
      checkLit("lb_stall1", 64'(bus32.wb_stall), 64'(e_stall[0]), 64'd1);
      applyStimulus(idleStim(1'b0, '0));
      applyStimulus(idleStim(1'b0, '0));
      checkLit("lb_stall3", 64'(bus32.wb_stall), 64'(e_stall[0]), 64'd1);
      applyStimulus(idleStim(1'b1, 64'h80FF_0000));
      checkLit("lb_result", 64'(bus32.result_out), e_result[0], 64'hFFFF_FF80);
      checkLit("lb_stall_drop", 64'(bus32.wb_stall), 64'(e_stall[0]), 64'd0);
      checkLit("lb_wen", 64'(bus32.reg_write_en_out), 64'(e_reg_en[0]), 64'd1);

      applyStimulus(instr(1'b1, 1'b0, 1'b0, 2'b01, 64'h2002, 1'b1, 5'd8));
      applyStimulus(idleStim(1'b1, 64'h8001_0000));
      checkLit("lhu_result", 64'(bus32.result_out), e_result[0], 64'h8001);

      applyStimulus(instr(1'b1, 1'b0, 1'b0, 2'b10, 64'h3002, 1'b1, 5'd9));
      checkLit("lw_mis_lae", 64'(bus32.load_addr_error), 64'(e_lae[0]), 64'd1);
      checkLit("lw_mis_bad", 64'(bus32.bad_vaddr), 64'(e_bad[0]), 64'h3002);
      checkLit("lw_mis_wen", 64'(bus32.reg_write_en_out), 64'(e_reg_en[0]), 64'd0);

      applyStimulus(instr(1'b1, 1'b0, 1'b0, 2'b10, 64'h100, 1'b1, 5'd10));
      for (int k = 1; k < TIMEOUT; k++) applyStimulus(idleStim(1'b0, '0));
      checkLit("to_stall_before", 64'(bus32.wb_stall), 64'(e_stall[0]), 64'd1);
      applyStimulus(idleStim(1'b0, '0));
      checkLit("to_bus_error", 64'(bus32.bus_error), 64'(e_be[0]), 64'd1);
      checkLit("to_bad", 64'(bus32.bad_vaddr), 64'(e_bad[0]), 64'h100);
      checkLit("to_stall_drop", 64'(bus32.wb_stall), 64'(e_stall[0]), 64'd0);
      applyStimulus(idleStim(1'b1, 64'hDEAD_BEEF));
      checkLit("to_late_wen", 64'(bus32.reg_write_en_out), 64'(e_reg_en[0]), 64'd0);
      checkLit("to_late_result", 64'(bus32.result_out), e_result[0], 64'h8001);

      applyStimulus(instr(1'b1, 1'b0, 1'b0, 2'b10, 64'h200, 1'b1, 5'd11));
      s = idleStim(1'b1, 64'h5555_5555);
      s.flush = 1'b1;
      applyStimulus(s);
      checkLit("flush_wen", 64'(bus32.reg_write_en_out), 64'(e_reg_en[0]), 64'd0);
      checkLit("flush_stall", 64'(bus32.wb_stall), 64'(e_stall[0]), 64'd0);

      applyStimulus(instr(1'b1, 1'b0, 1'b0, 2'b10, 64'h300, 1'b1, 5'd12));
      s = idleStim(1'b0, '0);
      s.rst = 1'b1;
      applyStimulus(s);
      checkLit("rst_wait_stall", 64'(bus32.wb_stall), 64'(e_stall[0]), 64'd0);
      applyStimulus(idleStim(1'b1, 64'h1111_2222));
      checkLit("rst_wait_wen", 64'(bus32.reg_write_en_out), 64'(e_reg_en[0]), 64'd0);

      applyStimulus(instr(1'b1, 1'b0, 1'b0, 2'b11, 64'h8, 1'b1, 5'd13));
      checkLit("ld32_lae", 64'(bus32.load_addr_error), 64'(e_lae[0]), 64'd1);
      checkLit("ld64_stall", 64'(bus64.wb_stall), 64'(e_stall[1]), 64'd1);
      applyStimulus(idleStim(1'b1, 64'h0123_4567_89AB_CDEF));
      checkLit("ld64_result", bus64.result_out, e_result[1], 64'h0123_4567_89AB_CDEF);
      applyStimulus(instr(1'b1, 1'b0, 1'b0, 2'b10, 64'hC, 1'b1, 5'd14));
      applyStimulus(idleStim(1'b1, 64'h0123_4567_89AB_CDEF));
      checkLit("lwu64_result", bus64.result_out, e_result[1], 64'h0000_0000_0123_4567);
      checkLit("lwu32_result", 64'(bus32.result_out), e_result[0], 64'h89AB_CDEF);

      for (int seg = 0; seg < 40; seg++) begin
         for (int c = 0; c < 60; c++) applyStimulus(randStim((seg % 4 == 3) ? 2 : (seg % 2)));
      end

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
